// File: rtl/sram_pkg.sv
// Shared definitions for the two-port arbitrated SRAM: port ids, legal read
// latencies and the per-stage response record.
package sram_pkg;

   localparam logic PORT_IFU = 1'b0;
   localparam logic PORT_LSU = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef struct packed {
      logic valid;
      logic port;
      logic err;
      logic is_write;
   } resp_stage_t;

   localparam resp_stage_t RESP_IDLE = '{valid: 1'b0, port: 1'b0, err: 1'b0, is_write: 1'b0};

   function automatic logic rd_lat_legal(input int lat);
      return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/sram_arb2_if.sv
// One requester port of the shared SRAM: req/gnt request handshake plus
// rvalid response channel.
interface sram_arb2_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 32
);
   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

   logic                  req;
   logic                  we;
   logic [NUM_BYTES-1:0]  be;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter; last_grant remembers the most recently served
// port and resets to port 1 so port 0 wins the first conflict.
module sram_rr_arb2
   import sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant_r;

   // Grant decode: lone requests pass through, conflicts go to the port not served last.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant_r == PORT_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Last-grant tracking, updated on every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= PORT_LSU;
      end else if (gnt[1]) begin
         last_grant_r <= PORT_LSU;
      end else if (gnt[0]) begin
         last_grant_r <= PORT_IFU;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

endmodule

// File: rtl/sram_arb2.sv
// Single-port word SRAM shared by instruction fetch (port 0) and LSU (port 1)
// with round-robin arbitration, byte-enabled writes and 1- or 2-cycle responses.
module sram_arb2
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_LAT     = 1
) (
   input logic        clk,
   input logic        rst_n,
   sram_arb2_if.slave p0,
   sram_arb2_if.slave p1
);

   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit TWO_STAGE = rd_lat_legal(RD_LAT) && (RD_LAT == RD_LAT_MAX);

   logic [1:0]            req_s;
   logic [1:0]            gnt_s;
   logic                  acc_s;
   logic                  sel_port_s;
   logic                  sel_we_s;
   logic [NUM_BYTES-1:0]  sel_be_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_wdata_s;
   logic                  in_range_s;
   logic [IDX_W-1:0]      idx_s;
   logic [DATA_WIDTH-1:0] raw_rdata_s;
   resp_stage_t           resp_s;
   resp_stage_t           fin_s;
   logic [DATA_WIDTH-1:0] fin_data_s;
   logic [DATA_WIDTH-1:0] out_data_s;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  p0_rvalid_r;
   logic                  p0_err_r;
   logic [DATA_WIDTH-1:0] p0_rdata_r;
   logic                  p1_rvalid_r;
   logic                  p1_err_r;
   logic [DATA_WIDTH-1:0] p1_rdata_r;

   assign req_s = {p1.req, p0.req};

   sram_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   assign p0.gnt    = gnt_s[0];
   assign p1.gnt    = gnt_s[1];
   assign p0.rvalid = p0_rvalid_r;
   assign p0.err    = p0_err_r;
   assign p0.rdata  = p0_rdata_r;
   assign p1.rvalid = p1_rvalid_r;
   assign p1.err    = p1_err_r;
   assign p1.rdata  = p1_rdata_r;

   // Steer the granted port's request onto the array and build its response record.
   always_comb begin
      acc_s = |gnt_s;
      if (gnt_s[1]) begin
         sel_port_s  = PORT_LSU;
         sel_we_s    = p1.we;
         sel_be_s    = p1.be;
         sel_addr_s  = p1.addr;
         sel_wdata_s = p1.wdata;
      end else begin
         sel_port_s  = PORT_IFU;
         sel_we_s    = p0.we;
         sel_be_s    = p0.be;
         sel_addr_s  = p0.addr;
         sel_wdata_s = p0.wdata;
      end
      // Widened compare keeps DEPTH == 2**ADDR_WIDTH from wrapping to zero.
      in_range_s      = {1'b0, sel_addr_s} < (ADDR_WIDTH + 1)'(DEPTH);
      idx_s           = sel_addr_s[IDX_W-1:0];
      raw_rdata_s     = mem[idx_s];
      resp_s.valid    = acc_s;
      resp_s.port     = sel_port_s;
      resp_s.err      = !in_range_s;
      resp_s.is_write = sel_we_s;
   end

   // Byte-lane writes into the array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (acc_s && sel_we_s && in_range_s && sel_be_s[i]) begin
            mem[idx_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= sel_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   generate
      if (TWO_STAGE) begin : g_lat2
         resp_stage_t           st1_r;
         logic [DATA_WIDTH-1:0] st1_data_r;

         // Extra response stage for the two-cycle latency configuration.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               st1_r      <= RESP_IDLE;
               st1_data_r <= '0;
            end else begin
               st1_r      <= resp_s;
               st1_data_r <= raw_rdata_s;
            end
         end

         assign fin_s      = st1_r;
         assign fin_data_s = st1_data_r;
      end else begin : g_lat1
         assign fin_s      = resp_s;
         assign fin_data_s = raw_rdata_s;
      end
   endgenerate

   assign out_data_s = (fin_s.is_write || fin_s.err) ? '0 : fin_data_s;

   // Per-port response registers; rdata holds between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rvalid_r <= 1'b0;
         p0_err_r    <= 1'b0;
         p0_rdata_r  <= '0;
         p1_rvalid_r <= 1'b0;
         p1_err_r    <= 1'b0;
         p1_rdata_r  <= '0;
      end else begin
         p0_rvalid_r <= fin_s.valid && (fin_s.port == PORT_IFU);
         p0_err_r    <= fin_s.valid && (fin_s.port == PORT_IFU) && fin_s.err;
         p1_rvalid_r <= fin_s.valid && (fin_s.port == PORT_LSU);
         p1_err_r    <= fin_s.valid && (fin_s.port == PORT_LSU) && fin_s.err;
         if (fin_s.valid && (fin_s.port == PORT_IFU)) begin
            p0_rdata_r <= out_data_s;
         end else begin
            p0_rdata_r <= p0_rdata_r;
         end
         if (fin_s.valid && (fin_s.port == PORT_LSU)) begin
            p1_rdata_r <= out_data_s;
         end else begin
            p1_rdata_r <= p1_rdata_r;
         end
      end
   end

endmodule

// File: tb/tb_sram_arb2.sv
// Directed bench for sram_arb2: one instance at RD_LAT=1, one at RD_LAT=2.
module tb_sram_arb2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   sram_arb2_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) a0 ();
   sram_arb2_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) a1 ();
   sram_arb2_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) b0 ();
   sram_arb2_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)) b1 ();

   sram_arb2 #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(1024), .ADDR_WIDTH(32), .RD_LAT(1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .p0    (a0),
      .p1    (a1)
   );

   sram_arb2 #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(1024), .ADDR_WIDTH(32), .RD_LAT(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .p0    (b0),
      .p1    (b1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a0(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      a0.req = req; a0.we = we; a0.be = be; a0.addr = addr; a0.wdata = wdata;
   endtask

   task automatic set_a1(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      a1.req = req; a1.we = we; a1.be = be; a1.addr = addr; a1.wdata = wdata;
   endtask

   task automatic set_b0(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      b0.req = req; b0.we = we; b0.be = be; b0.addr = addr; b0.wdata = wdata;
   endtask

   task automatic idle_all();
      set_a0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_a1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_b0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      b1.req = 1'b0; b1.we = 1'b0; b1.be = 4'h0; b1.addr = 32'h0; b1.wdata = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.err, a1.err} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got %b exp 000000", {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.err, a1.err});
      end
      tests_run++;
      if ({a0.rdata, a1.rdata} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_rdata got %h exp 0", {a0.rdata, a1.rdata});
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.err, a1.err} !== 6'b0) begin
         tests_failed++;
         $display("FAIL idle_ctrl got %b exp 000000", {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, a0.err, a1.err});
      end
      step();
      set_a0(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
      set_a1(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
      @(negedge clk);
      tests_run++;
      if ({a1.gnt, a0.gnt} !== 2'b01) begin
         tests_failed++;
         $display("FAIL first_conflict_gnt got %b exp 01", {a1.gnt, a0.gnt});
      end
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if ({a1.rvalid, a0.rvalid} !== 2'b01) begin
         tests_failed++;
         $display("FAIL first_conflict_rvalid got %b exp 01", {a1.rvalid, a0.rvalid});
      end
      step();
   endtask

   task automatic test_write_read();
      set_a1(1'b1, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF);
      @(negedge clk);
      tests_run++;
      if ({a1.gnt, a0.gnt} !== 2'b10) begin
         tests_failed++;
         $display("FAIL wr_gnt got %b exp 10", {a1.gnt, a0.gnt});
      end
      step();
      set_a1(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
      @(negedge clk);
      tests_run++;
      if ({a1.rvalid, a1.err, a1.rdata, a0.rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         tests_failed++;
         $display("FAIL wr_resp got rv=%b err=%b rdata=%h p0rv=%b exp rv=1 err=0 rdata=0 p0rv=0",
                  a1.rvalid, a1.err, a1.rdata, a0.rvalid);
      end
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if ({a1.rvalid, a1.err, a1.rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         tests_failed++;
         $display("FAIL rd_resp got rv=%b err=%b rdata=%h exp rv=1 err=0 rdata=deadbeef",
                  a1.rvalid, a1.err, a1.rdata);
      end
      step();
      @(negedge clk);
      tests_run++;
      if ({a1.rvalid, a1.rdata} !== {1'b0, 32'hDEADBEEF}) begin
         tests_failed++;
         $display("FAIL rdata_hold got rv=%b rdata=%h exp rv=0 rdata=deadbeef", a1.rvalid, a1.rdata);
      end
      step();
   endtask

   task automatic test_byte_enables();
      set_a1(1'b1, 1'b1, 4'b0101, 32'd5, 32'h11223344);
      step();
      set_a1(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if ({a1.rvalid, a1.rdata} !== {1'b1, 32'hDE22BE44}) begin
         tests_failed++;
         $display("FAIL byte_en got rv=%b rdata=%h exp rv=1 rdata=de22be44", a1.rvalid, a1.rdata);
      end
      step();
   endtask

   task automatic test_conflict();
      int i0;
      int i1;
      int ep;
      int ea;
      for (int k = 0; k < 3; k++) begin
         set_a1(1'b1, 1'b1, 4'hF, 32'(20 + k), 32'(256 + 20 + k));
         step();
         set_a1(1'b1, 1'b1, 4'hF, 32'(30 + k), 32'(256 + 30 + k));
         step();
      end
      idle_all();
      step();
      i0 = 0;
      i1 = 0;
      set_a0(1'b1, 1'b0, 4'h0, 32'd20, 32'h0);
      set_a1(1'b1, 1'b0, 4'h0, 32'd30, 32'h0);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c > 0) begin
            ep = (c - 1) % 2;
            ea = (ep == 1) ? (30 + (c - 1) / 2) : (20 + (c - 1) / 2);
            tests_run++;
            if ({a1.rvalid, a0.rvalid} !== ((ep == 1) ? 2'b10 : 2'b01)) begin
               tests_failed++;
               $display("FAIL rr_rvalid[%0d] got %b exp port %0d", c - 1, {a1.rvalid, a0.rvalid}, ep);
            end
            tests_run++;
            if (((ep == 1) ? a1.rdata : a0.rdata) !== 32'(256 + ea)) begin
               tests_failed++;
               $display("FAIL rr_rdata[%0d] got %h exp %h", c - 1,
                        (ep == 1) ? a1.rdata : a0.rdata, 32'(256 + ea));
            end
         end
         if (c < 6) begin
            tests_run++;
            if ({a1.gnt, a0.gnt} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
               tests_failed++;
               $display("FAIL rr_gnt[%0d] got %b exp %b", c, {a1.gnt, a0.gnt},
                        (c % 2 == 1) ? 2'b10 : 2'b01);
            end
         end
         step();
         if (c < 6) begin
            if (c % 2 == 0) begin
               i0++;
               a0.addr = 32'(20 + i0);
            end else begin
               i1++;
               a1.addr = 32'(30 + i1);
            end
         end
         if (c == 5) begin
            idle_all();
         end
      end
   endtask

   task automatic test_out_of_range();
      set_a0(1'b1, 1'b1, 4'hF, 32'd0, 32'h0BADF00D);
      step();
      set_a0(1'b1, 1'b1, 4'hF, 32'd1024, 32'hFFFFFFFF);
      step();
      set_a0(1'b1, 1'b0, 4'h0, 32'd1024, 32'h0);
      @(negedge clk);
      tests_run++;
      if ({a0.rvalid, a0.err, a0.rdata} !== {1'b1, 1'b1, 32'h0}) begin
         tests_failed++;
         $display("FAIL oor_wr got rv=%b err=%b rdata=%h exp rv=1 err=1 rdata=0", a0.rvalid, a0.err, a0.rdata);
      end
      step();
      set_a0(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
      @(negedge clk);
      tests_run++;
      if ({a0.rvalid, a0.err, a0.rdata} !== {1'b1, 1'b1, 32'h0}) begin
         tests_failed++;
         $display("FAIL oor_rd got rv=%b err=%b rdata=%h exp rv=1 err=1 rdata=0", a0.rvalid, a0.err, a0.rdata);
      end
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if ({a0.rvalid, a0.err, a0.rdata} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
         tests_failed++;
         $display("FAIL oor_addr0 got rv=%b err=%b rdata=%h exp rv=1 err=0 rdata=0badf00d",
                  a0.rvalid, a0.err, a0.rdata);
      end
      step();
   endtask

   task automatic test_rdlat2_reset();
      set_b0(1'b1, 1'b1, 4'hF, 32'd7, 32'hCAFE0007);
      @(negedge clk);
      tests_run++;
      if (b0.gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL l2_wr_gnt got %b exp 1", b0.gnt);
      end
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if (b0.rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL l2_wr_early got rv=%b exp 0", b0.rvalid);
      end
      step();
      @(negedge clk);
      tests_run++;
      if ({b0.rvalid, b0.err, b0.rdata} !== {1'b1, 1'b0, 32'h0}) begin
         tests_failed++;
         $display("FAIL l2_wr_resp got rv=%b err=%b rdata=%h exp rv=1 err=0 rdata=0", b0.rvalid, b0.err, b0.rdata);
      end
      step();
      set_b0(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
      step();
      idle_all();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (b0.rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL l2_flush[%0d] got rv=%b exp 0", k, b0.rvalid);
         end
         step();
      end
      set_a0(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
      set_a1(1'b1, 1'b0, 4'h0, 32'd0, 32'h0);
      @(negedge clk);
      tests_run++;
      if ({a1.gnt, a0.gnt} !== 2'b01) begin
         tests_failed++;
         $display("FAIL last_grant_restore got %b exp 01", {a1.gnt, a0.gnt});
      end
      step();
      idle_all();
      set_b0(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
      @(negedge clk);
      tests_run++;
      if (b0.gnt !== 1'b1) begin
         tests_failed++;
         $display("FAIL l2_rd_gnt got %b exp 1", b0.gnt);
      end
      step();
      idle_all();
      @(negedge clk);
      tests_run++;
      if (b0.rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL l2_rd_early got rv=%b exp 0", b0.rvalid);
      end
      step();
      @(negedge clk);
      tests_run++;
      if ({b0.rvalid, b0.err, b0.rdata} !== {1'b1, 1'b0, 32'hCAFE0007}) begin
         tests_failed++;
         $display("FAIL l2_rd_resp got rv=%b err=%b rdata=%h exp rv=1 err=0 rdata=cafe0007",
                  b0.rvalid, b0.err, b0.rdata);
      end
      step();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_write_read();
      test_byte_enables();
      test_conflict();
      test_out_of_range();
      test_rdlat2_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
